// File: rtl/conv_enc_2b1_framed.sv
// conv_enc_2b1_framed
//   Rate-1/2, K=3 convolutional encoder with trellis termination. Takes a
//   serial bit stream in frames of FRAME_LEN bits under valid/ready. After
//   each frame it appends two forced-zero tail bits, so every frame ends in
//   state 00. It emits one registered 2-bit symbol per encoded bit.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   in_valid   in_bit is valid this cycle
//   in_bit     serial data bit
//   in_ready   block accepts in_bit this cycle (low only while tailing)
//   sym_valid  sym_o is valid (one cycle per encoded bit)
//   sym_o      encoded symbol {G0 parity, G1 parity}
//   sym_first  marks the first symbol of a frame
//   sym_last   marks the last tail symbol of a frame
//   busy       FSM is not idle
//   frame_ct   number of terminated frames, wraps modulo 2^FCT_W

module conv_enc_2b1_framed #(
  parameter int unsigned FRAME_LEN = 32,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101,
  parameter int unsigned FCT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             sym_valid,
  output logic [1:0]       sym_o,
  output logic             sym_first,
  output logic             sym_last,
  output logic             busy,
  output logic [FCT_W-1:0] frame_ct
);

  // Bit counter holds values 0..FRAME_LEN-1.
  localparam int unsigned   CW       = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } state_e;

  state_e           state_q,     state_d;
  logic [1:0]       sr_q,        sr_d;
  logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic             tail_cnt_q,  tail_cnt_d;
  logic [FCT_W-1:0] frame_ct_q,  frame_ct_d;
  logic [1:0]       sym_q,       sym_d;
  logic             sym_valid_q, sym_valid_d;
  logic             first_q,     first_d;
  logic             last_q,      last_d;
  logic             busy_q,      busy_d;

  logic accept;
  logic do_enc;
  logic enc_bit;

  function automatic logic [1:0] encode(input logic b, input logic [1:0] sr);
    logic [2:0] v;
    v = {b, sr};
    return {^(v & G0), ^(v & G1)};
  endfunction

  assign in_ready = (state_q != TAIL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    frame_ct_d  = frame_ct_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    do_enc      = 1'b0;
    enc_bit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          do_enc    = 1'b1;
          enc_bit   = in_bit;
          first_d   = 1'b1;
          if (FRAME_LEN == 1) begin
            state_d   = TAIL;
            bit_cnt_d = '0;
          end else begin
            state_d   = DATA;
            bit_cnt_d = CW'(1);
          end
        end
      end

      DATA: begin
        if (accept) begin
          do_enc  = 1'b1;
          enc_bit = in_bit;
          // bit_cnt_q counts bits already taken; LAST_IDX means this is bit FRAME_LEN.
          if (bit_cnt_q == LAST_IDX) begin
            state_d   = TAIL;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      TAIL: begin
        // Two forced zeros flush the shift register back to 00.
        do_enc     = 1'b1;
        enc_bit    = 1'b0;
        tail_cnt_d = ~tail_cnt_q;
        if (tail_cnt_q) begin
          last_d     = 1'b1;
          frame_ct_d = frame_ct_q + FCT_W'(1);
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (do_enc) begin
      sym_d       = encode(enc_bit, sr_q);
      sr_d        = {enc_bit, sr_q[1]};
      sym_valid_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= 1'b0;
      frame_ct_q  <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      frame_ct_q  <= frame_ct_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_o     = sym_q;
  assign sym_first = first_q;
  assign sym_last  = last_q;
  assign busy      = busy_q;
  assign frame_ct  = frame_ct_q;

endmodule

// File: tb/tb_conv_enc_2b1_framed.sv
// Self-checking bench for conv_enc_2b1_framed (FRAME_LEN=4, FCT_W=2).

module tb_conv_enc_2b1_framed;

  localparam int         FL  = 4;
  localparam int         FW  = 2;
  localparam logic [2:0] TG0 = 3'b111;
  localparam logic [2:0] TG1 = 3'b101;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_ready;
  logic          sym_valid;
  logic [1:0]    sym_o;
  logic          sym_first;
  logic          sym_last;
  logic          busy;
  logic [FW-1:0] frame_ct;

  always #5 clk = ~clk;

  conv_enc_2b1_framed #(
    .FRAME_LEN(FL),
    .G0       (TG0),
    .G1       (TG1),
    .FCT_W    (FW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .sym_valid(sym_valid),
    .sym_o    (sym_o),
    .sym_first(sym_first),
    .sym_last (sym_last),
    .busy     (busy),
    .frame_ct (frame_ct)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the frame as a plain bit list and convolves it
  // with the generator taps. Tail zeros are appended to the same list.
  int       m_nbits;
  int       m_tail;
  int       m_frames;
  bit       m_hist[$];
  logic [1:0] got[$];
  int       last_fct[$];
  int       nrdy_low;

  function automatic logic [1:0] ref_sym();
    logic [2:0] g0;
    logic [2:0] g1;
    logic x0, x1, x2;
    int n;
    g0 = TG0;
    g1 = TG1;
    n  = m_hist.size() - 1;
    x0 = m_hist[n];
    x1 = (n >= 1) ? m_hist[n-1] : 1'b0;
    x2 = (n >= 2) ? m_hist[n-2] : 1'b0;
    return {(g0[2] & x0) ^ (g0[1] & x1) ^ (g0[0] & x2),
            (g1[2] & x0) ^ (g1[1] & x1) ^ (g1[0] & x2)};
  endfunction

  task automatic model_reset();
    m_nbits  = 0;
    m_tail   = 0;
    m_frames = 0;
    m_hist.delete();
    got.delete();
    last_fct.delete();
    nrdy_low = 0;
  endtask

  // One clock cycle: drive, check in_ready, advance the model, check outputs.
  task automatic cycle(input logic v, input logic b);
    logic       e_rdy, e_sv, e_first, e_last;
    logic [1:0] e_sym;
    in_valid = v;
    in_bit   = b;
    #1;
    e_rdy = (m_tail == 0);
    chk("in_ready", int'(in_ready), int'(e_rdy));
    if (!in_ready) nrdy_low++;
    e_sv = 1'b0; e_first = 1'b0; e_last = 1'b0; e_sym = 2'b00;
    if (m_tail > 0) begin
      m_hist.push_back(1'b0);
      e_sym = ref_sym();
      e_sv  = 1'b1;
      m_tail--;
      if (m_tail == 0) begin
        e_last = 1'b1;
        m_frames++;
        m_hist.delete();
      end
    end else if (v) begin
      m_hist.push_back(b);
      e_sym   = ref_sym();
      e_sv    = 1'b1;
      e_first = (m_nbits == 0);
      m_nbits++;
      if (m_nbits == FL) begin
        m_nbits = 0;
        m_tail  = 2;
      end
    end
    @(posedge clk);
    #1;
    chk("sym_valid", int'(sym_valid), int'(e_sv));
    if (e_sv) begin
      chk("sym_o", int'(sym_o), int'(e_sym));
      chk("sym_first", int'(sym_first), int'(e_first));
      chk("sym_last", int'(sym_last), int'(e_last));
    end
    chk("busy", int'(busy), int'(m_nbits != 0 || m_tail != 0));
    chk("frame_ct", int'(frame_ct), m_frames % (1 << FW));
    if (sym_valid) got.push_back(sym_o);
    if (sym_last) last_fct.push_back(int'(frame_ct));
  endtask

  task automatic do_reset(input logic v);
    in_valid = v;
    in_bit   = 1'b1;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_sym_o", int'(sym_o), 0);
    chk("rst_sym_first", int'(sym_first), 0);
    chk("rst_sym_last", int'(sym_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_ct", int'(frame_ct), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    model_reset();
  endtask

  task automatic chk_impulse(input string nm);
    logic [1:0] imp[6];
    imp = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    chk({nm, "_count"}, got.size(), 6);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) chk(nm, int'(got[i]), int'(imp[i]));
  endtask

  typedef struct {
    logic       v;
    logic       b;
    logic       rdy;
    logic       sv;
    logic [1:0] sym;
    logic       first;
    logic       last;
    logic       bsy;
    logic [1:0] fct;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #10000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Impulse 1,0,0,0 then tail; in_valid held high through tail.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1};
    // All-ones 1,1,1,1 then tail (after a reset).
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 2'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1};

    #2;
    do_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      if (i == 7) do_reset(1'b0);
      in_valid = tbl[i].v;
      in_bit   = tbl[i].b;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_sym_valid", i), int'(sym_valid), int'(tbl[i].sv));
      if (tbl[i].sv) begin
        chk($sformatf("tbl%0d_sym_o", i), int'(sym_o), int'(tbl[i].sym));
        chk($sformatf("tbl%0d_sym_first", i), int'(sym_first), int'(tbl[i].first));
        chk($sformatf("tbl%0d_sym_last", i), int'(sym_last), int'(tbl[i].last));
      end
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bsy));
      chk($sformatf("tbl%0d_frame_ct", i), int'(frame_ct), int'(tbl[i].fct));
    end

    // Gapped impulse: three idle cycles between bits 2 and 3.
    do_reset(1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    chk_impulse("gap_sym");
    chk("gap_frame_ct", int'(frame_ct), 1);

    // Reset mid-frame (with in_valid high), then a fresh impulse frame.
    do_reset(1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    do_reset(1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("midrst_no_sym", got.size(), 0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    chk_impulse("midrst_sym");
    chk("midrst_frame_ct", int'(frame_ct), 1);

    // Back-to-back: three frames with in_valid continuously high.
    do_reset(1'b0);
    for (int i = 0; i < 3 * (FL + 2); i++) cycle(1'b1, 1'($urandom_range(0, 1)));
    chk("b2b_symbols", got.size(), 18);
    chk("b2b_ready_low", nrdy_low, 6);
    chk("b2b_frame_ct", int'(frame_ct), 3);

    // Counter wrap with FCT_W=2 over five frames.
    do_reset(1'b0);
    for (int i = 0; i < 5 * (FL + 2); i++) cycle(1'b1, 1'($urandom_range(0, 1)));
    chk("wrap_count", last_fct.size(), 5);
    if (last_fct.size() == 5) begin
      chk("wrap_fct0", last_fct[0], 1);
      chk("wrap_fct1", last_fct[1], 2);
      chk("wrap_fct2", last_fct[2], 3);
      chk("wrap_fct3", last_fct[3], 0);
      chk("wrap_fct4", last_fct[4], 1);
    end

    // Random valid/data against the model.
    do_reset(1'b0);
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
